// File: rtl/led_fx_engine.sv
// LED effect sequencer: rotate-left, rotate-right, ping-pong and pattern playback,
// stepping once every programmable number of clock cycles.
// Optional brightness PWM on the output is built when LED_FX_PWM_EN is defined.
module led_fx_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         sw,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         period,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pat_we,
  input  logic [$clog2(DEPTH)-1:0] pat_addr,
  input  logic [WIDTH-1:0]         pat_wd,
  input  logic [3:0]               duty,
  output logic [WIDTH-1:0]         leds,
  output logic                     busy,
  output logic                     step_tick
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   eff_m1;
  logic [WIDTH-1:0]   frame_q;
  logic [WIDTH-1:0]   frame0;
  logic [WIDTH-1:0]   adv_frame;
  logic [WIDTH-1:0]   pp_up, pp_dn;
  logic [ADDR_W-1:0]  idx_q;
  logic [ADDR_W-1:0]  adv_idx;
  logic               dir_q;      // 1 = ping-pong moving towards the MSB
  logic               adv_dir;
  logic               cnt_hit;
  logic               load_en;
  logic               step_en;
  logic               step_tick_q;
  logic [WIDTH-1:0]   rd_next, rd_zero;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  // Pattern memory write port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (pat_we) mem_q[pat_addr] <= pat_wd;
  end

  assign adv_idx = idx_q + ADDR_W'(1);

  // Reads bypass a same-edge write so a slot rewritten on the step edge shows the new data.
  always_comb begin
    rd_next = mem_q[adv_idx];
    rd_zero = mem_q[0];
    if (pat_we && (pat_addr == adv_idx)) rd_next = pat_wd;
    if (pat_we && (pat_addr == '0))      rd_zero = pat_wd;
  end

  // A period of zero behaves as one.
  assign eff_m1  = (period_q == '0) ? '0 : period_q - CNT_W'(1);
  assign cnt_hit = (cnt_q == eff_m1);

  // First frame, selected from the live mode since it is latched on the same edge.
  always_comb begin
    frame0 = sw;
    unique case (mode)
      2'b00, 2'b01: frame0 = sw;
      2'b10:        frame0 = WIDTH'(1);
      2'b11:        frame0 = rd_zero;
      default:      frame0 = sw;
    endcase
  end

  assign pp_up = frame_q << 1;
  assign pp_dn = frame_q >> 1;

  // Next frame on a step, per latched mode.
  always_comb begin
    adv_frame = frame_q;
    adv_dir   = dir_q;
    unique case (mode_q)
      2'b00: adv_frame = {frame_q[WIDTH-2:0], frame_q[WIDTH-1]};
      2'b01: adv_frame = {frame_q[0], frame_q[WIDTH-1:1]};
      2'b10: begin
        // Flip direction as soon as the lit bit lands on an end, so no end frame repeats.
        if (dir_q) begin
          adv_frame = pp_up;
          if (pp_up[WIDTH-1]) adv_dir = 1'b0;
        end else begin
          adv_frame = pp_dn;
          if (pp_dn[0]) adv_dir = 1'b1;
        end
      end
      2'b11:   adv_frame = rd_next;
      default: adv_frame = frame_q;
    endcase
  end

  // Sequencer next-state and control strobes; stop always wins.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) state_d = StLoad;
      end
      StLoad: begin
        load_en = 1'b1;
        state_d = stop ? StIdle : StRun;
      end
      StRun: begin
        if (stop)         state_d = StIdle;
        else if (cnt_hit) step_en = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, latched configuration, counter and frame register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      period_q    <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      idx_q       <= '0;
      dir_q       <= 1'b1;
      step_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_tick_q <= step_en;
      if (load_en) begin
        mode_q   <= mode;
        period_q <= period;
        cnt_q    <= '0;
        frame_q  <= frame0;
        idx_q    <= '0;
        dir_q    <= 1'b1;
      end else if ((state_q == StRun) && !stop) begin
        cnt_q <= cnt_hit ? '0 : cnt_q + CNT_W'(1);
        if (step_en) begin
          frame_q <= adv_frame;
          idx_q   <= adv_idx;
          dir_q   <= adv_dir;
        end
      end
    end
  end

  assign busy      = (state_q == StLoad) || (state_q == StRun);
  assign step_tick = step_tick_q;

`ifdef LED_FX_PWM_EN
  logic [3:0] pwm_q;

  // Free-running brightness counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= 4'd0;
    else        pwm_q <= pwm_q + 4'd1;
  end

  assign leds = (duty == 4'hF) ? frame_q : (frame_q & {WIDTH{pwm_q < duty}});
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign leds        = frame_q;
`endif

endmodule

// File: tb/tb_led_fx_engine.sv
// Scoreboard bench for led_fx_engine: expected frames with their due cycle are queued
// by the stimulus; a monitor pops and compares on every step_tick.
module tb_led_fx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sw;
  logic [1:0]  mode;
  logic [31:0] period;
  logic        start, stop, pat_we;
  logic [2:0]  pat_addr;
  logic [7:0]  pat_wd;
  logic [3:0]  duty;
  logic [7:0]  leds;
  logic        busy, step_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int c0     = 0;

  typedef struct {
    logic [7:0] f;
    int         c;
  } exp_t;

  exp_t sb[$];

  led_fx_engine #(.WIDTH(8), .DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .sw(sw), .mode(mode), .period(period),
    .start(start), .stop(stop), .pat_we(pat_we), .pat_addr(pat_addr),
    .pat_wd(pat_wd), .duty(duty), .leds(leds), .busy(busy), .step_tick(step_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the head of the scoreboard, on the expected cycle.
  always @(negedge clk) begin
    if (step_tick) begin
      if (sb.size() == 0) begin
        chk("unexpected_tick", 32'd1, 32'd0);
      end else begin
        chk("tick_frame", {24'd0, leds}, {24'd0, sb[0].f});
        chk("tick_cycle", cyc, sb[0].c);
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && cyc > sb[0].c) begin
      chk("missed_tick", cyc, sb[0].c);
      void'(sb.pop_front());
    end
  end

  task automatic push(input logic [7:0] f, input int k, input int p);
    exp_t e;
    e.f = f;
    e.c = c0 + k * p;
    sb.push_back(e);
  endtask

  task automatic start_fx(input logic [7:0] s, input logic [1:0] m, input logic [31:0] p,
                          input logic [7:0] f0);
    @(negedge clk);
    sw = s; mode = m; period = p; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_load", {31'd0, busy}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("frame0", {24'd0, leds}, {24'd0, f0});
    chk("tick0", {31'd0, step_tick}, 32'd0);
    chk("busy_run", {31'd0, busy}, 32'd1);
    c0 = cyc;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic stop_fx(input logic [7:0] held);
    stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_tick", {31'd0, step_tick}, 32'd0);
    chk("stop_held", {24'd0, leds}, {24'd0, held});
    stop = 1'b0;
    @(posedge clk); #1;
    chk("idle_held", {24'd0, leds}, {24'd0, held});
  endtask

  logic [7:0] pp_exp [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] pb_exp [11] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h11,
                              8'h22, 8'h33, 8'hFF};

  initial begin
    reset = 1'b0; sw = 8'h00; mode = 2'b00; period = 32'd1;
    start = 1'b0; stop = 1'b0; pat_we = 1'b0; pat_addr = 3'd0; pat_wd = 8'h00;
    duty = 4'hF;
    #12;
    chk("rst_leds", {24'd0, leds}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tick", {31'd0, step_tick}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Rotate-left, period 3; mode/period changes mid-run must be ignored.
    start_fx(8'h81, 2'b00, 32'd3, 8'h81);
    mode = 2'b10; period = 32'd1;
    push(8'h03, 1, 3); push(8'h06, 2, 3); push(8'h0C, 3, 3);
    drain(100);
    stop_fx(8'h0C);

    // Ping-pong, period 1; stop lands on a step edge.
    start_fx(8'h00, 2'b10, 32'd1, 8'h01);
    for (int i = 0; i < 15; i++) push(pp_exp[i], i + 1, 1);
    drain(100);
    stop_fx(8'h02);

    // Playback with wrap and a rewrite of slot 3 on its own step edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pat_we = 1'b1; pat_addr = 3'(i); pat_wd = 8'(8'h11 * (i + 1));
    end
    @(negedge clk); pat_we = 1'b0;
    start_fx(8'h00, 2'b11, 32'd2, 8'h11);
    for (int i = 0; i < 11; i++) push(pb_exp[i], i + 1, 2);
    while (cyc < c0 + 21) @(negedge clk);
    pat_we = 1'b1; pat_addr = 3'd3; pat_wd = 8'hFF;
    @(negedge clk); pat_we = 1'b0;
    drain(100);
    stop_fx(8'hFF);

    // Rotate-right with period 0, which must step every cycle.
    start_fx(8'h01, 2'b01, 32'd0, 8'h01);
    push(8'h80, 1, 1); push(8'h40, 2, 1); push(8'h20, 3, 1);
    drain(100);
    stop_fx(8'h20);

    // Rotate with seed 0: frame stays 0, ticks continue.
    start_fx(8'h00, 2'b00, 32'd1, 8'h00);
    push(8'h00, 1, 1); push(8'h00, 2, 1);
    drain(100);
    stop_fx(8'h00);

    // start and stop together in IDLE: stays idle.
    @(negedge clk); sw = 8'hAA; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    chk("ss_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    chk("ss_busy2", {31'd0, busy}, 32'd0);
    chk("ss_leds", {24'd0, leds}, 32'd0);

    // stop during LOAD: back to idle with frame0 loaded.
    @(negedge clk); sw = 8'h5A; mode = 2'b00; period = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b1;
    @(posedge clk); #1;
    chk("ld_stop_busy", {31'd0, busy}, 32'd0);
    chk("ld_stop_leds", {24'd0, leds}, 32'h5A);
    stop = 1'b0;

`ifdef LED_FX_PWM_EN
    begin
      int on_cnt;
      start_fx(8'hFF, 2'b00, 32'd1000, 8'hFF);
      stop_fx(8'hFF);
      duty = 4'd4; on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (leds == 8'hFF) on_cnt++;
      end
      chk("pwm_duty4", on_cnt, 32'd4);
      duty = 4'd0; on_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (leds == 8'h00) on_cnt++;
      end
      chk("pwm_duty0", on_cnt, 32'd16);
      duty = 4'hF;
    end
`endif

    // Asynchronous reset mid-run clears outputs without a clock edge.
    start_fx(8'h3C, 2'b00, 32'd100, 8'h3C);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_leds", {24'd0, leds}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_tick", {31'd0, step_tick}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_leds", {24'd0, leds}, 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fx_engine.md
# led_fx_engine

Parametrised LED effect sequencer: the dedicated successor to the FSM/counter/register-file LED driver in the top level. It generates a `WIDTH`-bit LED frame stream in one of four modes (rotate left, rotate right, ping-pong, pattern playback). It steps once every programmable number of clock cycles. Playback frames come from a `DEPTH`-entry pattern memory. It sits between the switch inputs / pattern loader and the board LEDs, replacing the per-effect micro-sequencing in the top-level FSM.

## Interface
Parameters:
- `WIDTH`, 8, number of LEDs / frame bits (>= 2)
- `DEPTH`, 8, pattern memory entries (power of 2, >= 2)
- `CNT_W`, 32, period counter width

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sw`  in  WIDTH  seed frame for rotate modes, sampled at start
- `mode`  in  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 playback
- `period`  in  CNT_W  clock cycles per step; 0 treated as 1
- `start`  in  1  begin effect (level sampled each edge)
- `stop`  in  1  end effect
- `pat_we`  in  1  pattern memory write enable
- `pat_addr`  in  $clog2(DEPTH)  pattern write address
- `pat_wd`  in  WIDTH  pattern write data
- `duty`  in  4  brightness, used only with `LED_FX_PWM_EN`
- `leds`  out  WIDTH  LED frame output
- `busy`  out  1  high in LOAD and RUN
- `step_tick`  out  1  one-cycle pulse, high in the cycle a new frame first appears

## Operation
- States: IDLE, LOAD, RUN.
- IDLE:
  - `busy`=0; `leds` holds the last frame.
  - `start`=1 and `stop`=0 -> LOAD.
- LOAD (one cycle):
  - Latch `mode` and `period`; latch `sw` as the seed.
  - Clear the step counter; frame index = 0; ping-pong direction = up.
  - -> RUN, with `leds` = frame0.
- RUN:
  - Counter increments each cycle.
  - At count == eff_period-1 the counter clears, `leds` advances one frame, and `step_tick` pulses.
  - `stop`=1 -> IDLE; `leds` holds.
  - `start` is ignored; `mode`/`period` changes are ignored until the next LOAD.
- Frame0 per mode:
  - rotate modes: seed.
  - ping-pong: bit0 only.
  - playback: mem[0].
- Advance rules:
  - rotate-left: {f[WIDTH-2:0], f[WIDTH-1]}.
  - rotate-right: {f[0], f[WIDTH-1:1]}.
  - ping-pong: the single lit bit moves up to bit WIDTH-1, then down to bit0; direction flips on reaching an end, and no end frame is repeated.
  - playback: index increments and wraps DEPTH-1 -> 0; `leds` = mem[index].
- Pattern memory:
  - Write occurs on the edge when `pat_we`=1, in any state.
  - A write to the slot about to be shown is visible if it lands on or before the step edge.
  - Memory is not reset.
- Rotate with seed 0: `leds` stays 0 and steps still tick.

## Timing
- Reset (async assert, sync-released use): state IDLE, `leds`=0, `busy`=0, `step_tick`=0, counter=0, index=0.
- `start` sampled at edge N -> LOAD after N, `busy`=1 after N.
- At edge N+1: `leds`=frame0, state RUN, `step_tick`=0.
- Frame k appears at edge N+1+k·eff_period; `step_tick`=1 in exactly that following cycle.
- `stop` sampled at edge M in RUN -> IDLE after M, `busy`=0. If M is also a step edge, the frame does not advance and `step_tick` stays 0.
- `start` and `stop` in the same cycle: `stop` wins (IDLE stays IDLE; RUN goes IDLE).
- `stop` in LOAD: -> IDLE; frame0 is still loaded.
- Reset mid-operation: immediate return to the reset values listed above.
- Period counter compare is on the full CNT_W width. `period`=1 steps every cycle.

## Configuration
- `LED_FX_PWM_EN` defined:
  - A 4-bit free-running PWM counter runs from reset.
  - `leds` = frame & {WIDTH{pwm_cnt < duty}}, except `duty`=15 gives a constant frame.
  - `duty`=0 gives `leds`=0.
  - The internal frame register still follows all rules above; `step_tick` is unaffected.
- Not defined: `duty` is ignored, `leds` = frame register, and no PWM logic is built.

## Test plan
- Reset low mid-RUN with `leds`=0x3C -> `leds`=0x00, `busy`=0 immediately; IDLE after release.
- `sw`=0x81, mode 00, period 3, start -> 0x81, then 0x03 three cycles later, then 0x06; `step_tick` pulses every 3rd cycle.
- Mode 10, period 1, WIDTH 8 -> 01,02,04,…,80,40,20,…,01,02 on consecutive cycles.
- Write mem[0..7]=0x11·(i+1), mode 11, period 2 -> 0x11,0x22,…,0x88,0x11 (wrap); rewriting mem[3]=0xFF during RUN shows 0xFF at the next visit.
- `start`+`stop` together in IDLE -> stays IDLE; `stop` on a step edge -> frame held, no `step_tick`; `period`=0 behaves as 1.
- With `LED_FX_PWM_EN`, frame 0xFF, `duty`=4 -> `leds`=0xFF for 4 of every 16 cycles; `duty`=15 -> constant 0xFF; `duty`=0 -> constant 0x00.
